// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory-access stage and the data memory.
// DMEM_BYTE_EN_EN adds a per-byte store strobe.
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
`ifdef DMEM_BYTE_EN_EN
    logic [7:0]  req_wstrb_i;
`endif
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_error_o;

    modport master (
`ifdef DMEM_BYTE_EN_EN
        output req_wstrb_i,
`endif
        output req_valid_i,
        output req_write_i,
        output req_addr_i,
        output req_wdata_i,
        output resp_ready_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  resp_rdata_o,
        input  resp_error_o
    );

    modport slave (
`ifdef DMEM_BYTE_EN_EN
        input  req_wstrb_i,
`endif
        input  req_valid_i,
        input  req_write_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  resp_ready_i,
        output req_ready_o,
        output resp_valid_o,
        output resp_rdata_o,
        output resp_error_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Y86 data memory with configurable latency and address range check.
// Optional byte-strobed stores when DMEM_BYTE_EN_EN is defined.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_LIMIT  = 2047,
    parameter int LATENCY     = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    dmem_responder_if.slave bus,
    output logic busy_o
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [63:0] LIMIT    = 64'(ADDR_LIMIT);
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  CNT_LOAD =
        ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [3:0]         cnt;

    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [63:0]        wdata_q;
    logic               err_q;
`ifdef DMEM_BYTE_EN_EN
    logic [7:0]         wstrb_q;
`endif

    logic               resp_valid_q;
    logic [63:0]        resp_rdata_q;
    logic               resp_err_q;

    logic [63:0] mem [DEPTH_WORDS] = '{default: '0};

    logic               accept;
    logic               req_err;
    logic               enter_resp;
    logic               op_write;
    logic [IDX_W-1:0]   op_idx;
    logic [63:0]        op_wdata;
    logic [7:0]         op_strb;
    logic               op_err;
    logic [63:0]        op_rdata;

    assign accept  = bus.req_valid_i && (state == IDLE);
    assign req_err = bus.req_addr_i > LIMIT;

    // Operands for the memory access: live request when zero latency, else captured
    always_comb begin
        op_write = wr_q;
        op_idx   = idx_q;
        op_wdata = wdata_q;
        op_err   = err_q;
`ifdef DMEM_BYTE_EN_EN
        op_strb  = wstrb_q;
`else
        op_strb  = 8'hFF;
`endif
        if (state == IDLE) begin
            op_write = bus.req_write_i;
            op_idx   = bus.req_addr_i[3 +: IDX_W];
            op_wdata = bus.req_wdata_i;
            op_err   = req_err;
`ifdef DMEM_BYTE_EN_EN
            op_strb  = bus.req_wstrb_i;
`endif
        end
    end

    assign enter_resp = !rst_i &&
        ((accept && ZERO_LAT) ||
         (state == WAIT && cnt == 4'd0));

    assign op_rdata = (!op_write && !op_err) ? mem[op_idx] : '0;

    // Commit stores on the edge that enters RESP
    always_ff @(posedge clk_i) begin
        if (enter_resp && op_write && !op_err) begin
            for (int k = 0; k < 8; k++) begin
                if (op_strb[k]) begin
                    mem[op_idx][8*k +: 8] <= op_wdata[8*k +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
            wstrb_q      <= 8'h00;
`endif
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= bus.req_write_i;
                        idx_q   <= bus.req_addr_i[3 +: IDX_W];
                        wdata_q <= bus.req_wdata_i;
                        err_q   <= req_err;
`ifdef DMEM_BYTE_EN_EN
                        wstrb_q <= bus.req_wstrb_i;
`endif
                        if (ZERO_LAT) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= op_rdata;
                            resp_err_q   <= op_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= op_rdata;
                        resp_err_q   <= op_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = (state == IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.resp_error_o = resp_err_q;
    assign busy_o           = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array model.
// Unit 0 runs LATENCY=2, unit 1 runs LATENCY=0.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    logic busy0, busy1;

    dmem_responder_if b0();
    dmem_responder_if b1();

    dmem_responder #(.LATENCY(2)) u0 (
        .clk_i (clk),
        .rst_i (rst0),
        .bus   (b0),
        .busy_o(busy0)
    );

    dmem_responder #(.LATENCY(0)) u1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (b1),
        .busy_o(busy1)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] model [2][256];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int u, logic v, logic w, logic [63:0] a,
                       logic [63:0] d, logic [7:0] s);
        if (u == 0) begin
            b0.req_valid_i = v;
            b0.req_write_i = w;
            b0.req_addr_i  = a;
            b0.req_wdata_i = d;
`ifdef DMEM_BYTE_EN_EN
            b0.req_wstrb_i = s;
`endif
        end else begin
            b1.req_valid_i = v;
            b1.req_write_i = w;
            b1.req_addr_i  = a;
            b1.req_wdata_i = d;
`ifdef DMEM_BYTE_EN_EN
            b1.req_wstrb_i = s;
`endif
        end
    endtask

    task automatic rdy(int u, logic r);
        if (u == 0) b0.resp_ready_i = r;
        else        b1.resp_ready_i = r;
    endtask

    function automatic logic rv(int u);
        return (u == 0) ? b0.resp_valid_o : b1.resp_valid_o;
    endfunction
    function automatic logic [63:0] rd(int u);
        return (u == 0) ? b0.resp_rdata_o : b1.resp_rdata_o;
    endfunction
    function automatic logic re(int u);
        return (u == 0) ? b0.resp_error_o : b1.resp_error_o;
    endfunction
    function automatic logic rq(int u);
        return (u == 0) ? b0.req_ready_o : b1.req_ready_o;
    endfunction
    function automatic logic bz(int u);
        return (u == 0) ? busy0 : busy1;
    endfunction

    task automatic idle_chk(int u, string tag);
        chk({tag, "_valid"}, 64'(rv(u)), 64'd0);
        chk({tag, "_rdata"}, rd(u), 64'd0);
        chk({tag, "_err"},   64'(re(u)), 64'd0);
        chk({tag, "_busy"},  64'(bz(u)), 64'd0);
        chk({tag, "_ready"}, 64'(rq(u)), 64'd1);
    endtask

    // One full transaction; expected values come from the word-array model
    task automatic txn(int u, logic w, logic [63:0] a, logic [63:0] d,
                       logic [7:0] s, int hold, output logic [63:0] got);
        logic [7:0]  es;
        logic        e_err;
        logic [7:0]  idx;
        logic [63:0] e_rd;
        logic [63:0] held;
        int          n;
`ifdef DMEM_BYTE_EN_EN
        es = s;
`else
        es = 8'hFF;
`endif
        e_err = (a > 64'd2047);
        idx   = a[10:3];
        e_rd  = (w || e_err) ? 64'd0 : model[u][idx];
        if (w && !e_err) begin
            for (int k = 0; k < 8; k++)
                if (es[k]) model[u][idx][8*k +: 8] = d[8*k +: 8];
        end

        chk("req_ready_idle", 64'(rq(u)), 64'd1);
        rdy(u, 1'b0);
        drv(u, 1'b1, w, a, d, s);
        tick();
        drv(u, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
        n = 0;
        while (!rv(u) && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), (u == 0) ? 64'd2 : 64'd0);
        chk("rdata", rd(u), e_rd);
        chk("error", 64'(re(u)), 64'(e_err));
        got  = rd(u);
        held = rd(u);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_valid", 64'(rv(u)), 64'd1);
            chk("bp_rdata", rd(u), held);
            chk("bp_ready", 64'(rq(u)), 64'd0);
        end
        rdy(u, 1'b1);
        tick();
        rdy(u, 1'b0);
        chk("retire_valid", 64'(rv(u)), 64'd0);
        chk("retire_rdata", rd(u), 64'd0);
        chk("retire_ready", 64'(rq(u)), 64'd1);
    endtask

    function automatic logic [63:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      return {32'($urandom), 32'($urandom)} | 64'h1_0000;
        else if (r == 1) return 64'd2048 + 64'($urandom_range(0, 300));
        else if (r == 2) return 64'd2047;
        else             return 64'($urandom_range(0, 2047));
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] got;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 256; i++) model[u][i] = 64'd0;
        drv(0, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
        drv(1, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
        rdy(0, 1'b0);
        rdy(1, 1'b0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) tick();
        rst0 = 1'b0;
        rst1 = 1'b0;
        idle_chk(0, "rst0");
        idle_chk(1, "rst1");

        txn(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, got);
        txn(0, 1'b0, 64'h10, 64'd0, 8'hFF, 0, got);
        chk("load_10", got, 64'hDEADBEEF_CAFEF00D);

        txn(0, 1'b0, 64'h800, 64'd0, 8'hFF, 0, got);
        txn(0, 1'b0, 64'h0, 64'd0, 8'hFF, 0, got);
        txn(0, 1'b1, 64'h800, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, got);
        txn(0, 1'b0, 64'h0, 64'd0, 8'hFF, 0, got);
        chk("err_store_noalias", got, 64'd0);
        txn(0, 1'b0, 64'd2047, 64'd0, 8'hFF, 0, got);

        txn(0, 1'b0, 64'h10, 64'd0, 8'hFF, 5, got);

        chk("mid_ready", 64'(rq(0)), 64'd1);
        drv(0, 1'b1, 1'b1, 64'h20, 64'h1234, 8'hFF);
        tick();
        drv(0, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
        chk("mid_busy", 64'(bz(0)), 64'd1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        idle_chk(0, "mid_rst");
        repeat (4) tick();
        txn(0, 1'b0, 64'h20, 64'd0, 8'hFF, 0, got);
        chk("abort_nowrite", got, 64'd0);

        txn(0, 1'b1, 64'h18, 64'h55, 8'hFF, 0, got);
        txn(0, 1'b0, 64'h1F, 64'd0, 8'hFF, 1, got);
        chk("alias_1f", got, 64'h55);

`ifdef DMEM_BYTE_EN_EN
        txn(0, 1'b1, 64'h30, 64'h1111_1111_1111_1111, 8'hFF, 0, got);
        txn(0, 1'b1, 64'h30, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, got);
        txn(0, 1'b0, 64'h30, 64'd0, 8'hFF, 0, got);
        chk("strobe_0f", got, 64'h1111_1111_AAAA_AAAA);
        txn(0, 1'b1, 64'h30, 64'h5555_5555_5555_5555, 8'h00, 0, got);
        txn(0, 1'b0, 64'h30, 64'd0, 8'hFF, 0, got);
        chk("strobe_00", got, 64'h1111_1111_AAAA_AAAA);
`endif

        txn(1, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, got);
        txn(1, 1'b0, 64'h10, 64'd0, 8'hFF, 2, got);
        chk("l0_load_10", got, 64'hDEADBEEF_CAFEF00D);

        for (int i = 0; i < 120; i++) begin
            int          u;
            logic        w;
            logic [63:0] a;
            u = (i % 3 == 2) ? 1 : 0;
            w = 1'($urandom_range(0, 1));
            a = rnd_addr();
            txn(u, w, a, {32'($urandom), 32'($urandom)},
                8'($urandom), $urandom_range(0, 3), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
